pwm_audio_serializer: RTL

PWM_AUDIO_SERIALIZER -- requirements
Module: pwm_audio_serializer

---
 rtl/pwm_audio_serializer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pwm_audio_serializer.sv
// PWM audio serializer: one-deep duty shadow, slew-limited duty applied at period boundaries.
// pwm_out is one clk behind the period counter; duty_valid stalls while the shadow holds an unapplied value.
module pwm_audio_serializer #(
    parameter int PERIOD_CYCLES = 100,
    parameter int RAMP_STEP     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [6:0] duty_in,
    input  logic       duty_valid,
    output logic       duty_ready,
    input  logic       clip_clear,
    output logic       pwm_out,
    output logic       period_start,
    output logic [6:0] active_duty,
    output logic       clip_flag
);

    localparam logic [6:0] PERIOD = 7'(PERIOD_CYCLES);
    localparam logic [6:0] LAST   = 7'(PERIOD_CYCLES - 1);
    localparam logic [6:0] STEP   = 7'(RAMP_STEP);

    logic [6:0] cnt_q, cnt_d;
    logic [6:0] shadow_q, shadow_d;
    logic       shadow_full_q, shadow_full_d;
    logic [6:0] target_q, target_d;
    logic [6:0] active_q, active_d;
    logic       pwm_q, pwm_d;
    logic       clip_q, clip_d;
    logic       armed_q, armed_d;

    logic       boundary;
    logic       accept;
    logic       over_range;
    logic [6:0] diff;

    assign boundary   = enable && (cnt_q == LAST);
    assign accept     = duty_valid && !shadow_full_q;
    assign over_range = duty_in > PERIOD;

    always_comb begin
        cnt_d   = 7'd0;
        pwm_d   = enable && (cnt_q < active_q);
        armed_d = 1'b1;
        if (enable && !boundary) begin
            cnt_d = cnt_q + 7'd1;
        end
    end

    // The shadow is only handed over if it was full before this cycle, so an
    // accept landing on a boundary waits for the following one.
    always_comb begin
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        target_d      = target_q;
        if (boundary && shadow_full_q) begin
            target_d      = shadow_q;
            shadow_full_d = 1'b0;
        end
        if (accept) begin
            shadow_d      = over_range ? PERIOD : duty_in;
            shadow_full_d = 1'b1;
        end
    end

    always_comb begin
        active_d = active_q;
        diff     = 7'd0;
        if (boundary) begin
            if (target_d > active_q) begin
                diff     = target_d - active_q;
                active_d = active_q + ((diff > STEP) ? STEP : diff);
            end else if (target_d < active_q) begin
                diff     = active_q - target_d;
                active_d = active_q - ((diff > STEP) ? STEP : diff);
            end
        end
    end

    always_comb begin
        clip_d = clip_q;
        if (accept && over_range) begin
            clip_d = 1'b1;
        end else if (clip_clear) begin
            clip_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= 7'd0;
            shadow_q      <= 7'd0;
            shadow_full_q <= 1'b0;
            target_q      <= 7'd0;
            active_q      <= 7'd0;
            pwm_q         <= 1'b0;
            clip_q        <= 1'b0;
            armed_q       <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            target_q      <= target_d;
            active_q      <= active_d;
            pwm_q         <= pwm_d;
            clip_q        <= clip_d;
            armed_q       <= armed_d;
        end
    end

    // cnt only sits at 0 while enabled on the first cycle of a period (after a
    // wrap or an enable rise); armed_q keeps the pulse low through reset.
    assign period_start = enable && (cnt_q == 7'd0) && armed_q;
    assign duty_ready   = !shadow_full_q;
    assign pwm_out      = pwm_q;
    assign active_duty  = active_q;
    assign clip_flag    = clip_q;

endmodule
